// File: rtl/cursor_pkg.sv
// Shared constants and types for the cursor painter and its framebuffer stage.
package cursor_pkg;
    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 12;
    localparam int COORD_W = 11;
    localparam int SIZE_W  = 7;
    localparam int CMP_W   = COORD_W + 1;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
        logic               drop;
        logic               last;
    } s1_entry_t;

    // One extra bit so cursor+SIZE-1 cannot wrap back into the screen.
    function automatic logic [CMP_W-1:0] cmp_ext(input logic [COORD_W-1:0] v);
        return {1'b0, v};
    endfunction
endpackage

// File: rtl/fb_addr_calc.sv
// Registered framebuffer address y*H_RES + x, truncated to ADDR_W bits.
module fb_addr_calc
    import cursor_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr_q
);
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] x_w;
    logic [ADDR_W-1:0] y_w;

    // y*640 as y*512 + y*128; the address holds while the stage is stalled.
    always_comb begin
        x_w    = ADDR_W'(x);
        y_w    = ADDR_W'(y);
        addr_d = addr_q;
        if (load) begin
            addr_d = (y_w << 4'd9) + (y_w << 4'd7) + x_w;
        end else begin
            addr_d = addr_q;
        end
    end

    // Address register
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= {ADDR_W{1'b0}};
        end else begin
            addr_q <= addr_d;
        end
    end
endmodule

// File: rtl/grava_cursor_fb.sv
// Two-stage scan-to-framebuffer writer with clipping and square_done.
// Optional CURSOR_BORDER_ONLY_EN: write only the outline of the cursor square.
module grava_cursor_fb
    import cursor_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [COORD_W-1:0] x_coord,
    input  logic [COORD_W-1:0] y_coord,
    input  logic               coord_valid,
    output logic               coord_ready,
    input  logic [COORD_W-1:0] x_cursor,
    input  logic [COORD_W-1:0] y_cursor,
    input  logic [SIZE_W-1:0]  SIZE,
    input  logic [COLOR_W-1:0] color,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic               square_done
);
    localparam logic [CMP_W-1:0] H_LIMIT = CMP_W'(H_RES);
    localparam logic [CMP_W-1:0] V_LIMIT = CMP_W'(V_RES);

    logic               s1_valid_q, s1_valid_d;
    s1_entry_t          s1_q, s1_d;
    logic               s2_valid_q, s2_valid_d;
    logic [COLOR_W-1:0] s2_data_q, s2_data_d;
    logic               s2_drop_q, s2_drop_d;
    logic               s2_last_q, s2_last_d;

    logic s2_retire, s2_advance, s1_advance, accept;
    logic [CMP_W-1:0] x_ext, y_ext, x_end, y_end;
    logic drop, last, outline;

    // Handshake: a dropped entry retires at once, a write waits for mem_ready.
    always_comb begin
        s2_retire   = s2_valid_q && (s2_drop_q || mem_ready);
        s2_advance  = !s2_valid_q || s2_retire;
        s1_advance  = s1_valid_q && s2_advance;
        coord_ready = !s1_valid_q || s2_advance;
        accept      = coord_valid && coord_ready;
        square_done = s2_retire && s2_last_q;
    end

    // Per-pixel flags and next state of both stages.
    always_comb begin
        x_ext = cmp_ext(x_coord);
        y_ext = cmp_ext(y_coord);
        x_end = cmp_ext(x_cursor) + {5'd0, SIZE} - 12'd1;
        y_end = cmp_ext(y_cursor) + {5'd0, SIZE} - 12'd1;
`ifdef CURSOR_BORDER_ONLY_EN
        outline = (x_ext == cmp_ext(x_cursor)) || (x_ext == x_end) ||
                  (y_ext == cmp_ext(y_cursor)) || (y_ext == y_end);
`else
        outline = 1'b1;
`endif
        drop = (x_ext >= H_LIMIT) || (y_ext >= V_LIMIT) || (SIZE == 7'd0) || !outline;
        last = (SIZE != 7'd0) && (x_ext == x_end) && (y_ext == y_end);

        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = '{x: x_coord, y: y_coord, color: color, drop: drop, last: last};
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_drop_d  = s2_drop_q;
        s2_last_d  = s2_last_q;
        if (s1_advance) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s1_q.color;
            s2_drop_d  = s1_q.drop;
            s2_last_d  = s1_q.last;
        end else if (s2_retire) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '{x: 11'd0, y: 11'd0, color: 12'd0, drop: 1'b0, last: 1'b0};
            s2_valid_q <= 1'b0;
            s2_data_q  <= 12'd0;
            s2_drop_q  <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_drop_q  <= s2_drop_d;
            s2_last_q  <= s2_last_d;
        end
    end

    fb_addr_calc u_addr (
        .clock  (clock),
        .reset  (reset),
        .load   (s1_advance),
        .x      (s1_q.x),
        .y      (s1_q.y),
        .addr_q (mem_addr)
    );

    assign mem_data = s2_data_q;
    assign mem_we   = s2_valid_q && !s2_drop_q;
endmodule

// File: tb/tb_grava_cursor_fb.sv
// Directed plus randomized bench for grava_cursor_fb with a pixel-level reference model.
module tb_grava_cursor_fb;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x_coord = 11'd0, y_coord = 11'd0;
    logic        coord_valid = 1'b0;
    logic        coord_ready;
    logic [10:0] x_cursor = 11'd0, y_cursor = 11'd0;
    logic [6:0]  SIZE = 7'd0;
    logic [11:0] color = 12'd0;
    logic [18:0] mem_addr;
    logic [11:0] mem_data;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic        square_done;

    grava_cursor_fb dut (
        .clock(clock), .reset(reset), .x_coord(x_coord), .y_coord(y_coord),
        .coord_valid(coord_valid), .coord_ready(coord_ready), .x_cursor(x_cursor),
        .y_cursor(y_cursor), .SIZE(SIZE), .color(color), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready), .square_done(square_done)
    );

    always #5 clock = ~clock;

    typedef struct { int addr; int data; bit last; } wr_t;
    wr_t exp_q[$];
    int  wr_addrs[$];

    int tests = 0, fails = 0;
    int cyc = 0, rdy_mode = 0, pat_idx = 0;
    int writes_seen, done_seen, exp_done, accepts, first_acc, first_we, first_we_addr, done_addr;
    bit saw_not_ready, accepted, prev_stall;
    logic [18:0] prev_addr;
    logic [11:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: every accepted pixel judged directly from the drawing rules.
    task automatic model_accept();
        int x, y, xc, yc, sz, lx, ly;
        bit wr, lst;
        x = int'(x_coord); y = int'(y_coord);
        xc = int'(x_cursor); yc = int'(y_cursor); sz = int'(SIZE);
        lx = xc + sz - 1; ly = yc + sz - 1;
        wr  = (sz != 0) && (x < 640) && (y < 480);
`ifdef CURSOR_BORDER_ONLY_EN
        wr  = wr && (x == xc || x == lx || y == yc || y == ly);
`endif
        lst = (sz != 0) && (x == lx) && (y == ly);
        if (wr) exp_q.push_back('{addr: (y * 640 + x) % 524288, data: int'(color), last: lst});
        if (lst) exp_done++;
    endtask

    task automatic start_test();
        exp_q.delete(); wr_addrs.delete();
        writes_seen = 0; done_seen = 0; exp_done = 0; accepts = 0;
        first_acc = -1; first_we = -1; first_we_addr = -1; done_addr = -1;
        saw_not_ready = 0; pat_idx = 0;
    endtask

    task automatic tick();
        wr_t e;
        case (rdy_mode)
            0: mem_ready = 1'b1;
            1: begin mem_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3); pat_idx++; end
            default: mem_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        accepted = 0;
        if (!reset) begin
            if (prev_stall) begin
                check("stall_we", mem_we, 1);
                check("stall_addr", mem_addr, prev_addr);
                check("stall_data", mem_data, prev_data);
            end
            if (mem_we && !mem_ready) check("done_while_stalled", square_done, 0);
            if (mem_we && mem_ready) begin
                writes_seen++;
                wr_addrs.push_back(int'(mem_addr));
                if (first_we < 0) begin first_we = cyc; first_we_addr = int'(mem_addr); end
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_data, e.data);
                    check("done_with_write", square_done, e.last);
                end
            end
            if (square_done) begin done_seen++; done_addr = int'(mem_addr); end
            if (coord_valid && !coord_ready) saw_not_ready = 1;
            accepted = coord_valid && coord_ready;
            if (accepted) begin
                accepts++;
                if (first_acc < 0) first_acc = cyc;
                model_accept();
            end
            prev_stall = mem_we && !mem_ready;
            prev_addr = mem_addr; prev_data = mem_data;
        end else begin
            prev_stall = 0;
        end
        @(posedge clock); @(negedge clock);
        cyc++;
    endtask

    task automatic send_pixel(input int x, input int y);
        coord_valid = 1'b1; x_coord = 11'(x); y_coord = 11'(y);
        for (int k = 0; k < 64; k++) begin
            tick();
            if (accepted) break;
        end
        check("accept_timeout", accepted, 1);
    endtask

    task automatic drive_square(input int xc, input int yc, input int sz, input int col);
        x_cursor = 11'(xc); y_cursor = 11'(yc); SIZE = 7'(sz); color = 12'(col);
        for (int r = 0; r < sz; r++)
            for (int c = 0; c < sz; c++) send_pixel(xc + c, yc + r);
    endtask

    task automatic drain_and_close(input string tag);
        coord_valid = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_done_count"}, done_seen, exp_done);
    endtask

    initial begin
        rdy_mode = 0;
        start_test();
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_done", square_done, 0);
        check("rst_ready", coord_ready, 1);
        @(negedge clock);

        // Full square, memory always ready.
        start_test();
        drive_square(10, 20, 4, 12'hF00);
        drain_and_close("full");
        check("full_latency", first_we - first_acc, 2);
        check("full_first_addr", first_we_addr, 12810);
        check("full_writes", writes_seen, 16);
        check("full_done_once", done_seen, 1);
        check("full_done_addr", done_addr, 14733);

        // Same square under 1,0,0,1 backpressure.
        rdy_mode = 1;
        start_test();
        drive_square(10, 20, 4, 12'h0A5);
        drain_and_close("bp");
        check("bp_writes", writes_seen, 16);
        check("bp_done_once", done_seen, 1);
        check("bp_ready_dropped", saw_not_ready, 1);

        // Clipping at the bottom-right corner.
        rdy_mode = 0;
        start_test();
        drive_square(638, 478, 4, 12'h123);
        drain_and_close("clip");
        check("clip_writes", writes_seen, 4);
        check("clip_done", done_seen, 1);
        if (wr_addrs.size() == 4) begin
            check("clip_a0", wr_addrs[0], 306558);
            check("clip_a1", wr_addrs[1], 306559);
            check("clip_a2", wr_addrs[2], 307198);
            check("clip_a3", wr_addrs[3], 307199);
        end

        // SIZE = 0: everything accepted and dropped.
        start_test();
        x_cursor = 11'd100; y_cursor = 11'd100; SIZE = 7'd0; color = 12'hFFF;
        for (int i = 0; i < 5; i++) send_pixel(100 + i, 100);
        drain_and_close("size0");
        check("size0_accepts", accepts, 5);
        check("size0_writes", writes_seen, 0);
        check("size0_done", done_seen, 0);

`ifdef CURSOR_BORDER_ONLY_EN
        start_test();
        drive_square(0, 0, 4, 12'h0F0);
        drain_and_close("border");
        check("border_writes", writes_seen, 12);
        foreach (wr_addrs[i]) begin
            check("border_no_interior",
                  (wr_addrs[i] == 641) || (wr_addrs[i] == 642) ||
                  (wr_addrs[i] == 1281) || (wr_addrs[i] == 1282), 0);
        end
`endif

        // Randomized squares, colours, gaps and memory stalls.
        rdy_mode = 2;
        start_test();
        for (int s = 0; s < 30; s++) begin
            int xc, yc, sz;
            case ($urandom_range(0, 3))
                0: begin xc = $urandom_range(630, 645); yc = $urandom_range(470, 485); end
                1: begin xc = $urandom_range(2040, 2047); yc = $urandom_range(0, 10); end
                default: begin xc = $urandom_range(0, 635); yc = $urandom_range(0, 475); end
            endcase
            sz = $urandom_range(0, 6);
            x_cursor = 11'(xc); y_cursor = 11'(yc); SIZE = 7'(sz);
            for (int r = 0; r < sz + 1; r++) begin
                for (int c = 0; c < sz + 1; c++) begin
                    if ($urandom_range(0, 3) == 0) begin coord_valid = 1'b0; tick(); end
                    color = 12'($urandom);
                    send_pixel(xc + c, yc + r);
                end
            end
        end
        drain_and_close("rand");
        check("rand_some_done", done_seen > 0, 1);

        // Reset mid-stream flushes in-flight pixels.
        rdy_mode = 0;
        start_test();
        x_cursor = 11'd10; y_cursor = 11'd20; SIZE = 7'd4; color = 12'hF00;
        for (int i = 0; i < 6; i++) send_pixel(10 + (i % 4), 20 + i / 4);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b0; coord_valid = 1'b0;
        start_test();
        #1;
        check("midrst_we", mem_we, 0);
        check("midrst_done", square_done, 0);
        check("midrst_ready", coord_ready, 1);
        @(negedge clock);
        drain_and_close("midrst");
        check("midrst_writes", writes_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
